randomizer_lfsr: RTL and testbench



---
 rtl/randomizer_lfsr.sv | 166 ++++++++++++++++
 tb/tb_randomizer_lfsr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/randomizer_lfsr.sv
// Galois-LFSR randomizer: seedable LFSR plus a req/ready draw in [0, i_max].
// Optional draw counter output enabled by defining RANDOMIZER_STATS_EN.
module randomizer_lfsr #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                OUT_W     = 2,
    parameter int                MAX_TRIES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_req,
    input  logic [OUT_W-1:0]  i_max,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_r,
    output logic              o_valid,
    output logic              o_fallback,
`ifdef RANDOMIZER_STATS_EN
    output logic [15:0]       o_draw_cnt,
`endif
    output logic [LFSR_W-1:0] o_lfsr
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    if (LFSR_W < 4 || LFSR_W > 32 || OUT_W < 1 || OUT_W > LFSR_W ||
        OUT_W > 8 || MAX_TRIES < 1 || SEED == '0) begin : g_bad_param
        $error("randomizer_lfsr: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [OUT_W-1:0]  max_q, max_d;
    logic [OUT_W-1:0]  mask_q, mask_d;
    logic [OUT_W-1:0]  r_q, r_d;
    logic              valid_q, valid_d;
    logic              fb_q, fb_d;
    logic [OUT_W-1:0]  mask_c;
    logic [OUT_W-1:0]  cand;

    // A seed load wins over stepping; zero seeds map to SEED to avoid lockup.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_seed_load) begin
            lfsr_d = (i_seed == '0) ? SEED : i_seed;
        end else if (i_en) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    // Smear the highest set bit downward to get the smallest 2^k-1 >= i_max.
    always_comb begin
        mask_c = i_max;
        for (int i = 1; i < OUT_W; i++) begin
            mask_c = mask_c | (mask_c >> i);
        end
    end

    assign cand = lfsr_q[OUT_W-1:0] & mask_q;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        max_d   = max_q;
        mask_d  = mask_q;
        r_d     = r_q;
        valid_d = valid_q;
        fb_d    = fb_q;
        unique case (state_q)
            IDLE: begin
                if (i_en && i_req) begin
                    max_d   = i_max;
                    mask_d  = mask_c;
                    tries_d = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (i_en) begin
                    if (cand <= max_q) begin
                        r_d     = cand;
                        valid_d = 1'b1;
                        fb_d    = 1'b0;
                        state_d = HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        r_d     = cand >> 1;
                        valid_d = 1'b1;
                        fb_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            tries_q <= '0;
            max_q   <= '0;
            mask_q  <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tries_q <= tries_d;
            max_q   <= max_d;
            mask_q  <= mask_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            fb_q    <= fb_d;
        end
    end

`ifdef RANDOMIZER_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && i_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_draw_cnt = cnt_q;
`endif

    assign o_r        = r_q;
    assign o_valid    = valid_q;
    assign o_fallback = fb_q;
    assign o_lfsr     = lfsr_q;

endmodule

// File: tb/tb_randomizer_lfsr.sv
// Self-checking bench for randomizer_lfsr against a transaction-level model.
module tb_randomizer_lfsr;

    localparam int          LW   = 16;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          OW   = 2;
    localparam int          MT   = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed      = '0;
    logic        req       = 1'b0;
    logic [1:0]  mx        = '0;
    logic        ready     = 1'b0;
    logic [1:0]  o_r;
    logic        o_valid;
    logic        o_fallback;
    logic [15:0] o_lfsr;
`ifdef RANDOMIZER_STATS_EN
    logic [15:0] o_draw_cnt;
`endif

    int          checks   = 0;
    int          errors   = 0;
    int          accepted = 0;
    logic [15:0] m_lfsr   = SEED;
    logic [1:0]  last_r;
    bit          last_fb;

    randomizer_lfsr #(
        .LFSR_W(LW), .TAPS(TAPS), .SEED(SEED), .OUT_W(OW), .MAX_TRIES(MT)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_en(en),
        .i_seed_load(seed_load),
        .i_seed(seed),
        .i_req(req),
        .i_max(mx),
        .i_ready(ready),
        .o_r(o_r),
        .o_valid(o_valid),
        .o_fallback(o_fallback),
`ifdef RANDOMIZER_STATS_EN
        .o_draw_cnt(o_draw_cnt),
`endif
        .o_lfsr(o_lfsr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] x);
        return (x / 16'd2) ^ ((x % 16'd2 == 16'd1) ? TAPS : 16'h0);
    endfunction

    // Draw outcome from the LFSR value seen by the first GEN cycle.
    function automatic void predict(input logic [15:0] l0, input int mxv,
                                    output logic [1:0] r, output bit fb,
                                    output int t);
        logic [15:0] l = l0;
        int mask = 0;
        int c = 0;
        while (mask < mxv) mask = mask * 2 + 1;
        r = '0;
        fb = 1'b1;
        t = MT - 1;
        for (int k = 0; k < MT; k++) begin
            c = int'(l % 16'd4) & mask;
            if (c <= mxv) begin
                r = 2'(c);
                fb = 1'b0;
                t = k;
                return;
            end
            l = step(l);
        end
        r = 2'(c / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_lfsr = SEED;
        else if (seed_load) m_lfsr = (seed == 16'h0) ? SEED : seed;
        else if (en) m_lfsr = step(m_lfsr);
        #1;
        chk("lfsr", o_lfsr, m_lfsr);
    endtask

    task automatic draw(input logic [1:0] mxv, input int hold_n,
                        input int pause_n, input bit scramble,
                        input bit do_load, input logic [15:0] sv);
        logic [1:0] er;
        bit efb;
        int et;
        int cyc;
        en = 1'b1;
        ready = 1'b0;
        req = 1'b1;
        mx = mxv;
        if (do_load) begin
            seed_load = 1'b1;
            seed = sv;
        end
        tick();
        req = 1'b0;
        seed_load = 1'b0;
        predict(m_lfsr, int'(mxv), er, efb, et);
        chk("valid_gen", o_valid, 0);
        if (pause_n > 0) begin
            en = 1'b0;
            repeat (pause_n) begin
                if (scramble) begin
                    mx = 2'($urandom);
                    req = 1'b1;
                end
                tick();
                chk("valid_pause", o_valid, 0);
            end
            en = 1'b1;
            req = 1'b0;
        end
        cyc = 0;
        while (!o_valid && cyc < MT + 4) begin
            if (scramble) begin
                mx = 2'($urandom);
                req = 1'($urandom);
                ready = 1'($urandom);
            end
            tick();
            cyc++;
        end
        ready = 1'b0;
        req = 1'b0;
        chk("latency", cyc, et + 1);
        chk("r", o_r, er);
        chk("fallback", o_fallback, efb);
        chk("in_range", (o_r <= mxv), 1);
        repeat (hold_n) begin
            req = 1'($urandom);
            mx = 2'($urandom);
            en = 1'($urandom);
            tick();
            chk("hold_valid", o_valid, 1);
            chk("hold_r", o_r, er);
            chk("hold_fb", o_fallback, efb);
        end
        req = 1'b0;
        en = 1'($urandom);
        ready = 1'b1;
        tick();
        accepted++;
        ready = 1'b0;
        en = 1'b1;
        chk("accept", o_valid, 0);
        last_r = er;
        last_fb = efb;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_lfsr", o_lfsr, 16'hACE1);
        chk("rst_valid", o_valid, 0);
        chk("rst_r", o_r, 0);
        chk("rst_fb", o_fallback, 0);

        rst_n = 1'b1;
        en = 1'b1;
        tick();
        chk("seq1", o_lfsr, 16'hE270);
        chk("seq1_valid", o_valid, 0);
        tick();
        chk("seq2", o_lfsr, 16'h7138);
        chk("seq2_valid", o_valid, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        draw(2'd3, 5, 0, 1'b0, 1'b0, 16'h0);
        chk("tp_first_r", last_r, 0);

        en = 1'b0;
        seed_load = 1'b1;
        seed = 16'h0000;
        tick();
        chk("seed_zero", o_lfsr, 16'hACE1);
        seed = 16'h0001;
        tick();
        chk("seed_one", o_lfsr, 16'h0001);
        seed_load = 1'b0;
        en = 1'b1;
        tick();
        chk("seed_step", o_lfsr, 16'hB400);

        for (int i = 0; i < 100; i++) begin
            draw(2'd0, 0, 0, 1'b0, 1'b0, 16'h0);
            chk("max0_r", last_r, 0);
            chk("max0_fb", last_fb, 0);
        end

        draw(2'd2, 1, 0, 1'b0, 1'b1, 16'h03FF);
        chk("forced_fb", last_fb, 1);
        chk("forced_r", last_r, 1);

        draw(2'd3, 0, 0, 1'b1, 1'b0, 16'h0);
        chk("full_range_fb", last_fb, 0);

        draw(2'd2, 2, 4, 1'b1, 1'b1, 16'h03FF);
        chk("pause_fb", last_fb, 1);

        req = 1'b1;
        mx = 2'd1;
        tick();
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_r", o_r, 0);
        chk("midrst_fb", o_fallback, 0);
`ifdef RANDOMIZER_STATS_EN
        accepted = 0;
`endif
        draw(2'd1, 1, 0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 300; i++) begin
            draw(2'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 4 : 0, 1'b1,
                 ($urandom_range(0, 7) == 0), 16'($urandom));
        end

`ifdef RANDOMIZER_STATS_EN
        chk("draw_cnt", o_draw_cnt, 16'(accepted));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
